// File: rtl/de0_mem_arb_pkg.sv
// Shared constants and read-pipeline record for the on-chip RAM arbiter.
// No logic, so no latency.
// No flow control of its own.
package de0_mem_arb_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int NUM_WORDS = 8960;

  // Populated depth at address width, so the range compare needs no widening
  localparam logic [ADDR_W-1:0] NUM_WORDS_A = ADDR_W'(NUM_WORDS);

  // One read slot in flight: who asked, and whether it fell past the populated depth
  typedef struct packed {
    logic valid;
    logic id;
    logic oor;
  } rd_pipe_t;

endpackage

// File: rtl/de0_rr_arb2.sv
// Two-requester round-robin grant; the loser of a contention wins next time.
// Grant is combinational from requests and last_grant; last_grant updates on acceptance.
// A losing requester is expected to hold its request; it wins no later than next cycle.
module de0_rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  // 1 means requester 1 won most recently, so requester 0 takes the next contention
  logic last_grant;

  // Lone requester always wins; on contention the one not granted last wins
  always_comb begin
    grant0 = req0 & (~req1 | last_grant);
    grant1 = req1 & (~req0 | ~last_grant);
  end

  // Remember the winner of every accepted cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (req0 | req1) begin
      last_grant <= grant1;
    end
  end

endmodule

// File: rtl/de0_onchip_mem_arb.sv
// Round-robin shares the single-port on-chip RAM between two Avalon-MM masters.
// Command path combinational; read data returns 2 cycles after acceptance.
// Loser of a contention sees waitrequest for one cycle; out-of-range writes accepted and dropped.
import de0_mem_arb_pkg::*;

module de0_onchip_mem_arb (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic m0_req;
  logic m1_req;
  logic grant0;
  logic grant1;
  logic win_write;
  logic win_read;
  logic in_range;

  rd_pipe_t          s1;
  rd_pipe_t          s2;
  rd_pipe_t          s1_nxt;
  logic [DATA_W-1:0] rd_data;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  de0_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (m0_req),
    .req1    (m1_req),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  assign m0_waitrequest = m0_req & ~grant0;
  assign m1_waitrequest = m1_req & ~grant1;

  // Steer the winner onto the RAM pins; when idle m0's fields pass through with no write
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    win_write      = grant0 & m0_write;
    win_read       = grant0 & m0_read & ~m0_write;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      win_write      = m1_write;
      win_read       = m1_read & ~m1_write;
    end
  end

  // A read+write request counts as a write only, so it never enters the read pipe
  assign in_range       = mem_address < NUM_WORDS_A;
  assign mem_write      = win_write & in_range;
  assign mem_chipselect = mem_write;
  assign mem_clken      = reset_n;
  assign mem_reset_req  = 1'b0;

  // Describe the read being issued this cycle
  always_comb begin
    s1_nxt       = '0;
    s1_nxt.valid = win_read;
    s1_nxt.id    = grant1;
    s1_nxt.oor   = ~in_range;
  end

  // Two-stage read return; reset flushes anything in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      rd_data <= '0;
    end else begin
      s1 <= s1_nxt;
      s2 <= s1;
      if (s1.valid) begin
        rd_data <= s1.oor ? '0 : mem_readdata;
      end
    end
  end

  assign m0_readdata      = rd_data;
  assign m1_readdata      = rd_data;
  assign m0_readdatavalid = s2.valid & (s2.id == 1'b0);
  assign m1_readdatavalid = s2.valid & (s2.id == 1'b1);

endmodule

// File: tb/tb_de0_onchip_mem_arb.sv
module tb_de0_onchip_mem_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [31:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  de0_onchip_mem_arb dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata)
  );

  // Physical RAM behind the DUT: registered address, combinational output
  logic [31:0] ram [16384];
  logic [13:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    ram_addr_q <= mem_address;
  end
  assign mem_readdata = ram[ram_addr_q];

  // Reference model: contents the RAM ought to hold, who won last, reads owed
  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic [31:0] mdl_mem [16384];
  logic        mdl_last;
  exp_t        owed [$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        w0 = 1'b0, w1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  // One clock: check mid-cycle against the model, then commit the model at the edge
  task automatic cycle();
    logic r0, r1, g0, g1, ww, wr, inr, ev0, ev1;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] wd, ed;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (r0 && r1) begin g0 = mdl_last; g1 = !mdl_last; end
    else begin g0 = r0; g1 = r1; end
    a  = g1 ? m1_address : m0_address;
    be = g1 ? m1_byteenable : m0_byteenable;
    wd = g1 ? m1_writedata : m0_writedata;
    ww = g1 ? m1_write : (g0 & m0_write);
    wr = g1 ? (m1_read & !m1_write) : (g0 & m0_read & !m0_write);
    inr = (int'(a) < 8960);
    chk("m0_waitrequest", 32'(m0_waitrequest), 32'(r0 & !g0));
    chk("m1_waitrequest", 32'(m1_waitrequest), 32'(r1 & !g1));
    chk("mem_write", 32'(mem_write), 32'(ww & inr));
    chk("mem_chipselect", 32'(mem_chipselect), 32'(ww & inr));
    chk("mem_clken", 32'(mem_clken), 32'd1);
    if (g0 || g1) chk("mem_address", 32'(mem_address), 32'(a));
    if (ww && inr) chk("mem_writedata", mem_writedata, wd);
    ev0 = 0; ev1 = 0; ed = '0;
    if (owed.size() > 0 && owed[0].due == cyc) begin
      ev0 = !owed[0].id; ev1 = owed[0].id; ed = owed[0].data;
      void'(owed.pop_front());
    end
    chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(ev0));
    chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(ev1));
    if (ev0) chk("m0_readdata", m0_readdata, ed);
    if (ev1) chk("m1_readdata", m1_readdata, ed);
    w0 = r0 & !g0;
    w1 = r1 & !g1;
    @(posedge clk);
    if (g0 || g1) begin
      mdl_last = g1;
      if (ww && inr)
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl_mem[a][8*b +: 8] = wd[8*b +: 8];
      if (wr) owed.push_back('{due: cyc + 2, id: g1, data: inr ? mdl_mem[a] : 32'h0});
    end
    cyc++;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [13:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 14'($urandom_range(8950, 8970));
    return 14'($urandom_range(0, 63));
  endfunction

  initial begin
    int k;
    for (int i = 0; i < 16384; i++) begin
      ram[i]     = 32'hA5A5_0000 | 32'(i);
      mdl_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    reset_n = 0;
    idle_inputs();
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    mdl_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m0_readdatavalid", 32'(m0_readdatavalid), 32'd0);
    chk("rst_m1_readdatavalid", 32'(m1_readdatavalid), 32'd0);
    chk("rst_m0_readdata", m0_readdata, 32'd0);
    chk("rst_m1_readdata", m1_readdata, 32'd0);
    chk("rst_mem_clken", 32'(mem_clken), 32'd0);
    chk("rst_mem_reset_req", 32'(mem_reset_req), 32'd0);
    reset_n = 1;

    // Lone read from m0
    m0_read = 1; m0_address = 14'h0005;
    cycle();
    idle_cycles(4);

    // Both masters read continuously; losers hold their fields
    m0_read = 1; m1_read = 1;
    for (int i = 0; i < 6; i++) begin
      if (!w0) m0_address = 14'(16'h40 + i);
      if (!w1) m1_address = 14'(16'h80 + i);
      cycle();
    end
    idle_cycles(4);

    // Partial write from m1, then m0 reads it back the next cycle
    m1_write = 1; m1_address = 14'h0010; m1_byteenable = 4'b0011; m1_writedata = 32'h1234_5678;
    cycle();
    idle_inputs();
    m0_read = 1; m0_address = 14'h0010;
    cycle();
    idle_cycles(4);
    chk("ram_0010", ram[16'h0010], 32'hA5A5_5678);

    // Out-of-range write dropped, out-of-range read returns zero
    m0_write = 1; m0_address = 14'h2300; m0_byteenable = 4'hF; m0_writedata = 32'hDEAD_BEEF;
    cycle();
    idle_inputs();
    m0_read = 1;
    cycle();
    idle_cycles(4);
    chk("ram_2300", ram[16'h2300], 32'hA5A5_2300);

    // Read and write together is a write with no return
    m0_read = 1; m0_write = 1; m0_address = 14'h0020; m0_writedata = 32'hCAFE_F00D;
    cycle();
    idle_cycles(4);
    chk("ram_0020", ram[16'h0020], 32'hCAFE_F00D);

    // Reset pulse while a read is in flight
    m0_read = 1; m0_address = 14'h0005;
    cycle();
    idle_inputs();
    #2 reset_n = 0;
    owed.delete();
    mdl_last = 1'b1;
    #1;
    chk("rstp_m0_readdatavalid", 32'(m0_readdatavalid), 32'd0);
    chk("rstp_readdata", m0_readdata, 32'd0);
    @(posedge clk);
    #1 reset_n = 1;
    idle_cycles(4);
    m0_read = 1; m1_read = 1; m0_address = 14'h0001; m1_address = 14'h0002;
    cycle();
    chk("post_rst_m1_loses", 32'(w1), 32'd1);
    m0_read = 0;
    cycle();
    idle_cycles(4);

    // Random traffic with Avalon hold-under-waitrequest behaviour
    for (int i = 0; i < 400; i++) begin
      if (!w0) begin
        k = $urandom_range(0, 9);
        m0_read = (k < 4) || (k == 9);
        m0_write = (k >= 4 && k < 7) || (k == 9);
        m0_address = rand_addr();
        m0_byteenable = 4'($urandom_range(0, 15));
        m0_writedata = $urandom;
      end
      if (!w1) begin
        k = $urandom_range(0, 9);
        m1_read = (k < 4) || (k == 9);
        m1_write = (k >= 4 && k < 7) || (k == 9);
        m1_address = rand_addr();
        m1_byteenable = 4'($urandom_range(0, 15));
        m1_writedata = $urandom;
      end
      cycle();
    end
    idle_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
